mem_io_responder: RTL
=====================

MEM_IO_RESPONDER -- requirements
Module: mem_io_responder

Interface
REQ-001 Parameter RAM_ADDR_W, default 17: RAM index width; the RAM holds 2^17 bytes.
REQ-002 Parameter IO_FIFO_DEPTH, default 8: depth of the output byte FIFO, power of two.
REQ-003 Parameter FULL_MARGIN, default 2: free-slot headroom at which the full flag asserts.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 rdy  input  1  global enable; when low, no state changes (see REQ-016).
REQ-007 mem_rw  input  1  1 = write, 0 = read.
REQ-008 mem_addr  input  32  byte address from the memory controller.
REQ-009 mem_din  input  8  write byte from the memory controller.
REQ-010 mem_dout  output  8  read byte to the memory controller, registered.
REQ-011 io_buffer_full  output  1  backpressure to the memory controller.
REQ-012 tx_data  output  8  FIFO head byte.
REQ-013 tx_valid  output  1  FIFO non-empty.
REQ-014 tx_ready  input  1  sink accepts tx_data this cycle.
REQ-015 io_overflow  output  1  sticky: an IO write was dropped.

Function
REQ-016 When rdy=0, RAM, FIFO, count, mem_dout and io_overflow SHALL hold; tx_valid/tx_data still reflect FIFO state, and no pop occurs.
REQ-017 io_sel SHALL be mem_addr[17:16]==2'b11 (0x30000-0x3FFFF); otherwise the RAM index SHALL be mem_addr[RAM_ADDR_W-1:0], and higher address bits SHALL be ignored.
REQ-018 Read, RAM: mem_dout SHALL equal ram[index] one cycle after the address is presented (1-cycle latency; an address at cycle k gives data at cycle k+1).
REQ-019 Read, io_sel: mem_dout SHALL become 8'h00 the next cycle, with no side effect.
REQ-020 Write, RAM: ram[index] SHALL take mem_din at the edge; a read of the same index in the next cycle SHALL return the new byte.
REQ-021 Write, io_sel: mem_din SHALL be pushed into the FIFO unless the FIFO is full; on full, the byte SHALL be dropped and io_overflow set.
REQ-022 A write cycle SHALL leave mem_dout unchanged.
REQ-023 A pop SHALL occur when tx_valid and tx_ready are both 1 and rdy=1; tx_data SHALL be the head entry, combinational from FIFO storage.
REQ-024 Push and pop in the same cycle SHALL both take effect, leave count unchanged, and SHALL be legal at full; a push into an empty FIFO SHALL not be popped in the same cycle.
REQ-025 The FIFO SHALL use read/write pointers of log2(depth) bits that wrap modulo depth, and a count of log2(depth)+1 bits.
REQ-026 io_buffer_full SHALL be registered and equal 1 iff count >= IO_FIFO_DEPTH-FULL_MARGIN after the current edge; it SHALL deassert when count falls below the threshold.
REQ-027 io_overflow SHALL clear only on reset.

Reset
REQ-028 On rst_n low, asynchronously: mem_dout=0, FIFO pointers=0, count=0, io_buffer_full=0, io_overflow=0, hence tx_valid=0.
REQ-029 RAM contents SHALL NOT be reset (preloadable via a $readmemh hook).
REQ-030 Reset asserted mid-transfer SHALL discard FIFO contents; the first cycle after deassertion SHALL behave as idle.

Structure
REQ-031 The IO base (2'b11 at [17:16]), Read/Write encodings, and the 8-bit memory data width SHALL live in the shared config package, alongside AddrBus/MemDataBus.
REQ-032 The FIFO SHALL be one sub-module, byte_fifo (push, pop, din, dout, count, full, empty), instantiated once.

Verification
REQ-033 Write 8'hA5 to 0x00010, then read 0x00010 the next cycle -> mem_dout=8'hA5 one cycle after the read address.
REQ-034 Four consecutive reads of 0x100-0x103 after writing 11,22,33,44 -> mem_dout returns 11,22,33,44 on cycles k+1..k+4.
REQ-035 With tx_ready=0, six writes to 0x30000 -> io_buffer_full=1 after the sixth edge; two further writes succeed; a ninth write sets io_overflow=1 and count stays 8.
REQ-036 Full FIFO, tx_ready=1, push every cycle -> count stays 8, bytes emerge in order, io_overflow unchanged.
REQ-037 rdy=0 for 3 cycles during a write burst plus tx_ready=1 -> no RAM write, no pop, and mem_dout held.
REQ-038 Assert rst_n low with 5 bytes queued -> tx_valid=0, io_buffer_full=0 immediately; RAM byte at 0x00010 still 8'hA5.

Source files
------------

// File: rtl/mem_io_pkg.sv
// mem_io_pkg: shared address map, bus types and read/write encodings
package mem_io_pkg;
  localparam int MEM_DATA_W = 8;
  localparam int ADDR_W = 32;
  localparam logic [1:0] IO_BASE = 2'b11;
  localparam logic RW_READ = 1'b0;
  localparam logic RW_WRITE = 1'b1;
  typedef logic [ADDR_W-1:0] addr_bus_t;
  typedef logic [MEM_DATA_W-1:0] mem_data_bus_t;
endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// byte_fifo: wrapping-pointer byte FIFO; caller only issues legal push/pop
module byte_fifo
  import mem_io_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic                     pop,
  input  mem_data_bus_t            din,
  output mem_data_bus_t            dout,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);
  localparam int AW = $clog2(DEPTH);
  mem_data_bus_t mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  assign dout = mem[rd_ptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop) count <= count + 1'b1;
      else if (!push && pop) count <= count - 1'b1;
    end
endmodule

// File: rtl/mem_io_responder.sv
// mem_io_responder: byte RAM plus memory-mapped IO output FIFO for a memory controller
module mem_io_responder
  import mem_io_pkg::*;
#(
  parameter int RAM_ADDR_W = 17,
  parameter int IO_FIFO_DEPTH = 8,
  parameter int FULL_MARGIN = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          rdy,
  input  logic          mem_rw,
  input  addr_bus_t     mem_addr,
  input  mem_data_bus_t mem_din,
  output mem_data_bus_t mem_dout,
  output logic          io_buffer_full,
  output mem_data_bus_t tx_data,
  output logic          tx_valid,
  input  logic          tx_ready,
  output logic          io_overflow
);
  localparam int CW = $clog2(IO_FIFO_DEPTH) + 1;
  localparam logic [CW-1:0] THRESH = CW'(IO_FIFO_DEPTH - FULL_MARGIN);
  mem_data_bus_t ram [2**RAM_ADDR_W];
  logic [RAM_ADDR_W-1:0] idx;
  logic [CW-1:0] count, count_next;
  logic io_sel, is_rd, is_wr, io_wr, push, pop, full, empty, unused_addr;
  assign io_sel = mem_addr[17:16] == IO_BASE;
  assign idx = mem_addr[RAM_ADDR_W-1:0];
  assign unused_addr = ^mem_addr;
  assign is_rd = mem_rw == RW_READ;
  assign is_wr = mem_rw == RW_WRITE;
  assign io_wr = rdy && is_wr && io_sel;
  assign pop = rdy && !empty && tx_ready;
  assign push = io_wr && (!full || pop);
  assign tx_valid = !empty;
  assign count_next = count + CW'(push) - CW'(pop);
  always_ff @(posedge clk)
    if (rdy && is_wr && !io_sel) ram[idx] <= mem_din;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      mem_dout <= '0;
      io_buffer_full <= 1'b0;
      io_overflow <= 1'b0;
    end else if (rdy) begin
      mem_dout <= is_rd ? (io_sel ? '0 : ram[idx]) : mem_dout;
      io_buffer_full <= count_next >= THRESH;
      io_overflow <= io_overflow | (io_wr & !push);
    end
  byte_fifo #(.DEPTH(IO_FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst_n(rst_n),
    .push(push),
    .pop(pop),
    .din(mem_din),
    .dout(tx_data),
    .count(count),
    .full(full),
    .empty(empty)
  );
endmodule
